// File: rtl/icache_responder.sv
// rtl/icache_responder.sv - direct-mapped read-only instruction cache, fetch-bus responder side
// Sync-read tag/data arrays, flop valid bits, single-outstanding line refill from backing memory.
module icache_responder #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 6,
  parameter int OFFSET_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     i_p_addr,
  input  logic [DATA_W/8-1:0]   i_p_byte_en,
  input  logic [DATA_W-1:0]     i_p_writedata,
  input  logic                  i_p_read,
  input  logic                  i_p_write,
  output logic [DATA_W-1:0]     o_p_readdata,
  output logic                  o_p_readdata_valid,
  output logic                  o_p_waitrequest,
  input  logic                  flush_i,
  output logic [ADDR_W-1:0]     m_addr,
  output logic                  m_read,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdata_valid
);
  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [1:0] {RUN, REFILL, RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [TAG_W-1:0]    r_tag [LINES];
  logic [DATA_W-1:0]   r_data [WORDS][LINES];
  logic [LINES-1:0]    r_valid;
  logic [TAG_W-1:0]    r_rd_tag;
  logic [DATA_W-1:0]   r_rd_line [WORDS];
  logic [ADDR_W-1:0]   r_req_addr;
  logic                r_lk_v;
  logic [OFFSET_W-1:0] r_cnt;
  logic                r_issued;
  logic                r_flush_seen;
  logic [DATA_W-1:0]   r_resp_word;

  logic [INDEX_W-1:0]  w_in_idx;
  logic [TAG_W-1:0]    w_req_tag;
  logic [INDEX_W-1:0]  w_req_idx;
  logic [OFFSET_W-1:0] w_req_off;
  logic                w_hit;
  logic                w_miss;
  logic                w_rvalid;
  logic                w_last;
  logic                w_can_accept;
  logic                w_accept_rd;
  logic                w_unused;

  assign w_in_idx  = i_p_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_req_tag = r_req_addr[ADDR_W-1:INDEX_W+OFFSET_W];
  assign w_req_idx = r_req_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
  assign w_req_off = r_req_addr[OFFSET_W-1:0];

  // Valid is read live so a flush in the lookup cycle only affects later lookups.
  assign w_hit    = r_lk_v & r_valid[w_req_idx] & (r_rd_tag == w_req_tag);
  assign w_miss   = (r_state == RUN) & r_lk_v & ~w_hit;
  assign w_rvalid = (r_state == REFILL) & r_issued & m_readdata_valid;
  assign w_last   = w_rvalid & (r_cnt == {OFFSET_W{1'b1}});
  assign w_accept_rd = w_can_accept & i_p_read;
  assign w_unused = ^{i_p_byte_en, i_p_writedata, i_p_write};

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt        = r_state;
    o_p_waitrequest    = 1'b0;
    o_p_readdata_valid = 1'b0;
    o_p_readdata       = '0;
    m_read             = 1'b0;
    m_addr             = '0;
    w_can_accept       = 1'b0;
    case (r_state)
      RUN: begin
        if (r_lk_v && w_hit) begin
          o_p_readdata_valid = 1'b1;
          o_p_readdata       = r_rd_line[w_req_off];
          w_can_accept       = 1'b1;
        end else if (r_lk_v) begin
          o_p_waitrequest = 1'b1;
          w_state_nxt     = REFILL;
        end else begin
          w_can_accept = 1'b1;
        end
      end
      REFILL: begin
        o_p_waitrequest = 1'b1;
        m_read          = ~r_issued;
        m_addr          = {w_req_tag, w_req_idx, r_cnt};
        if (w_last) w_state_nxt = RESP;
      end
      RESP: begin
        o_p_readdata_valid = 1'b1;
        o_p_readdata       = r_resp_word;
        w_can_accept       = 1'b1;
        w_state_nxt        = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lk_v       <= 1'b0;
      r_valid      <= '0;
      r_req_addr   <= '0;
      r_cnt        <= '0;
      r_issued     <= 1'b0;
      r_flush_seen <= 1'b0;
      r_resp_word  <= '0;
    end else begin
      r_lk_v <= w_accept_rd;
      if (w_accept_rd) r_req_addr <= i_p_addr;
      if (w_miss) begin
        r_cnt        <= '0;
        r_issued     <= 1'b0;
        r_flush_seen <= 1'b0;
      end
      if (r_state == REFILL) begin
        if (m_read && !m_waitrequest) r_issued <= 1'b1;
        if (w_rvalid) begin
          r_issued <= 1'b0;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == w_req_off) r_resp_word <= m_readdata;
        end
        if (flush_i) r_flush_seen <= 1'b1;
      end
      if (flush_i)                      r_valid <= '0;
      else if (w_last && !r_flush_seen) r_valid[w_req_idx] <= 1'b1;
    end
  end

  // Array storage and its registered read port carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_rvalid) r_data[r_cnt][w_req_idx] <= m_readdata;
    if (!rst && w_last)   r_tag[w_req_idx] <= w_req_tag;
    if (w_accept_rd) begin
      r_rd_tag <= r_tag[w_in_idx];
      for (int w = 0; w < WORDS; w++) r_rd_line[w] <= r_data[w][w_in_idx];
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb/tb_icache_responder.sv - directed self-checking bench for icache_responder
// Backing memory model: 2-cycle read latency, optional stall on one word of a refill.
module tb_icache_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] i_p_addr;
  logic [3:0]  i_p_byte_en;
  logic [31:0] i_p_writedata;
  logic        i_p_read;
  logic        i_p_write;
  logic [31:0] o_p_readdata;
  logic        o_p_readdata_valid;
  logic        o_p_waitrequest;
  logic        flush_i;
  logic [24:0] m_addr;
  logic        m_read;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        m_readdata_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] addr_log[$];
  int          stall_left = 0;
  logic [1:0]  stall_word = 2'd0;
  logic [24:0] stall_addr = '0;

  icache_responder dut (
    .clk(clk), .rst(rst),
    .i_p_addr(i_p_addr), .i_p_byte_en(i_p_byte_en), .i_p_writedata(i_p_writedata),
    .i_p_read(i_p_read), .i_p_write(i_p_write),
    .o_p_readdata(o_p_readdata), .o_p_readdata_valid(o_p_readdata_valid),
    .o_p_waitrequest(o_p_waitrequest), .flush_i(flush_i),
    .m_addr(m_addr), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdata_valid(m_readdata_valid)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [24:0] a);
    if (a[24:2] == 23'd4) return 32'hA0 + {30'd0, a[1:0]};
    return 32'hC000_0000 | {7'd0, a};
  endfunction

  // Memory model acts at negedges: an accept seen here happens at the next posedge.
  initial begin
    int          lat;
    logic [24:0] pend;
    bit          stall_active;
    lat = 0; pend = '0; stall_active = 0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdata_valid = 1'b0;
    forever begin
      @(negedge clk);
      m_readdata_valid = 1'b0;
      if (lat > 0) begin
        lat--;
        if (lat == 0) begin
          m_readdata_valid = 1'b1;
          m_readdata = mem_word(pend);
        end
      end
      if (stall_left > 0 && (stall_active || (m_read && m_addr[1:0] == stall_word))) begin
        stall_active = 1;
        m_waitrequest = 1'b1;
        stall_left--;
        expect_eq("stall_m_read", {31'd0, m_read}, 32'd1);
        expect_eq("stall_m_addr", {7'd0, m_addr}, {7'd0, stall_addr});
      end else begin
        stall_active = 0;
        m_waitrequest = 1'b0;
      end
      if (m_read && !m_waitrequest) begin
        lat = 2;
        pend = m_addr;
        addr_log.push_back(m_addr);
      end
    end
  end

  // Issue one read from an idle/accepting negedge and wait for its data.
  task automatic fetch(input string tag, input logic [24:0] a, input logic [31:0] exp,
                       input int exp_lat, input int flush_at);
    int n, nwait;
    i_p_read = 1'b1; i_p_addr = a;
    @(negedge clk);
    i_p_read = 1'b0;
    n = 1; nwait = 0;
    while (!o_p_readdata_valid && n < 300) begin
      if (o_p_waitrequest) nwait++;
      if (n == flush_at) flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      n++;
    end
    expect_eq({tag, "_valid"}, {31'd0, o_p_readdata_valid}, 32'd1);
    expect_eq({tag, "_data"}, o_p_readdata, exp);
    expect_eq({tag, "_lat"}, n, exp_lat);
    expect_eq({tag, "_wait"}, nwait, exp_lat - 1);
  endtask

  initial begin
    int saw_valid;
    rst = 1'b1; i_p_addr = '0; i_p_byte_en = 4'hF; i_p_writedata = '0;
    i_p_read = 1'b0; i_p_write = 1'b0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    expect_eq("rst_readdata", o_p_readdata, 32'd0);
    expect_eq("rst_valid", {31'd0, o_p_readdata_valid}, 32'd0);
    expect_eq("rst_wait", {31'd0, o_p_waitrequest}, 32'd0);
    expect_eq("rst_m_read", {31'd0, m_read}, 32'd0);
    expect_eq("rst_m_addr", {7'd0, m_addr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    addr_log.delete();
    fetch("cold", 25'h10, 32'hA0, 14, 0);
    expect_eq("cold_nreq", addr_log.size(), 4);
    for (int k = 0; k < 4 && k < addr_log.size(); k++)
      expect_eq("cold_m_addr", {7'd0, addr_log[k]}, 32'h10 + k);
    @(negedge clk);
    expect_eq("cold_pulse", {31'd0, o_p_readdata_valid}, 32'd0);

    addr_log.delete();
    i_p_read = 1'b1; i_p_addr = 25'h10;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_p_addr = 25'h11 + k;
      if (k == 3) i_p_read = 1'b0;
      expect_eq("hit_valid", {31'd0, o_p_readdata_valid}, 32'd1);
      expect_eq("hit_data", o_p_readdata, 32'hA0 + k);
      expect_eq("hit_wait", {31'd0, o_p_waitrequest}, 32'd0);
      expect_eq("hit_m_read", {31'd0, m_read}, 32'd0);
    end
    expect_eq("hit_nreq", addr_log.size(), 0);

    i_p_write = 1'b1; i_p_addr = 25'h10; i_p_writedata = 32'hDEAD;
    @(negedge clk);
    i_p_write = 1'b0;
    expect_eq("wr_valid", {31'd0, o_p_readdata_valid}, 32'd0);
    expect_eq("wr_wait", {31'd0, o_p_waitrequest}, 32'd0);
    fetch("wr_hit", 25'h10, 32'hA0, 1, 0);

    addr_log.delete();
    fetch("conf", 25'h110, 32'hC000_0110, 14, 0);
    if (addr_log.size() > 0) expect_eq("conf_m_addr", {7'd0, addr_log[0]}, 32'h110);
    else expect_eq("conf_nreq", addr_log.size(), 4);
    fetch("conf_back", 25'h10, 32'hA0, 14, 0);

    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    fetch("flush", 25'h10, 32'hA0, 14, 0);
    fetch("flush_mid", 25'h112, 32'hC000_0112, 14, 5);
    fetch("flush_mid_again", 25'h112, 32'hC000_0112, 14, 0);

    stall_word = 2'd1; stall_addr = 25'h11; stall_left = 5;
    fetch("stall", 25'h10, 32'hA0, 19, 0);
    expect_eq("stall_used", stall_left, 0);

    i_p_read = 1'b1; i_p_addr = 25'h210;
    @(negedge clk);
    i_p_read = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    expect_eq("mid_rst_readdata", o_p_readdata, 32'd0);
    expect_eq("mid_rst_valid", {31'd0, o_p_readdata_valid}, 32'd0);
    expect_eq("mid_rst_wait", {31'd0, o_p_waitrequest}, 32'd0);
    expect_eq("mid_rst_m_read", {31'd0, m_read}, 32'd0);
    expect_eq("mid_rst_m_addr", {7'd0, m_addr}, 32'd0);
    rst = 1'b0;
    saw_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_p_readdata_valid) saw_valid++;
    end
    expect_eq("late_resp_valid", saw_valid, 0);
    fetch("post_rst", 25'h10, 32'hA0, 14, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Direct-mapped, read-only instruction cache; the responder end of the core's fetch cache bus (word address, byte enable, write data, read/write strobes, read data plus valid, waitrequest).
- Serves fetch reads with one-cycle hit latency and back-to-back pipelining.
- On a miss, stalls the fetch side with waitrequest and refills the whole line from a single-outstanding backing-memory read port, then returns the requested word.

Parameters:
ADDR_W, 25, CPU-side word-address width
DATA_W, 32, data width
INDEX_W, 6, set index bits (64 lines)
OFFSET_W, 2, word-in-line bits (4 words/line); TAG_W = ADDR_W-INDEX_W-OFFSET_W = 17

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_p_addr  in  ADDR_W  word address from fetch
i_p_byte_en  in  DATA_W/8  ignored (read-only cache)
i_p_writedata  in  DATA_W  ignored
i_p_read  in  1  read request
i_p_write  in  1  write request (accepted, discarded)
o_p_readdata  out  DATA_W  read data
o_p_readdata_valid  out  1  read data valid, 1-cycle pulse per accepted read
o_p_waitrequest  out  1  responder busy; requests not accepted while high
flush_i  in  1  invalidate all lines (fence.i)
m_addr  out  ADDR_W  backing-memory word address
m_read  out  1  backing-memory read strobe
m_waitrequest  in  1  backing memory busy; read accepted when m_read & !m_waitrequest
m_readdata  in  DATA_W  backing read data
m_readdata_valid  in  1  backing read data valid

Behaviour:
- Reset values: o_p_readdata=0, o_p_readdata_valid=0, o_p_waitrequest=0, m_read=0, m_addr=0; all valid bits cleared; state RUN; lookup pending flag lk_v=0.
- o_p_waitrequest is driven only from registered state and array outputs, never combinationally from i_p_read; the initiator computes read = ~waitrequest, so any such path is a loop.
- Acceptance: a read is accepted when i_p_read=1 and o_p_waitrequest=0 in RUN. The tag/data array (sync read) is indexed by i_p_addr[INDEX_W+OFFSET_W-1:OFFSET_W]. The address is latched into req_addr and lk_v<=1.
- Writes: i_p_write accepted under the same rule and discarded. There is no readdata_valid and no array change. If read and write are both high, the read is served.
- States:
  - RUN, lk_v=1 (lookup cycle): hit = valid[idx] & tag==req_addr tag.
    - Hit: o_p_readdata_valid=1 and o_p_readdata=line word[req offset] this cycle; waitrequest=0. A new request may be accepted in the same cycle, giving 1 word/cycle streaming.
    - Miss: o_p_waitrequest=1 combinationally from the compare. No acceptance this cycle. Go to REFILL with cnt=0.
  - REFILL: m_addr={req tag, idx, cnt}, m_read=1 until m_waitrequest=0, then m_read=0 until m_readdata_valid. Each returned word is written to the data array at idx, word cnt, and cnt increments. After word 2^OFFSET_W-1, write the tag and set valid (unless a flush occurred during the refill); go to RESP. o_p_waitrequest=1 throughout.
  - RESP (1 cycle): o_p_readdata_valid=1 with the requested word from the refill buffer; o_p_waitrequest=0, so the next request may be accepted. Next state RUN with lk_v set per acceptance.
- Only one memory read is outstanding at a time; m_readdata_valid outside REFILL is ignored.
- flush_i: clears all valid bits in one cycle.
  - Flush during REFILL: the refill completes, valid is NOT set, and the requested word is still returned.
  - Flush in the lookup cycle: the lookup result uses the pre-flush valid.
  - Flush coincident with an acceptance: the next lookup sees cleared valids.
- rst mid-REFILL: immediate abort; m_read=0, state RUN. Late memory responses after reset are ignored.
- Address arithmetic: index/offset/tag are pure bit slices. cnt wraps modulo 2^OFFSET_W and the refill always starts at word 0.
- Miss latency: accept cycle + lookup cycle + 4 memory transactions + RESP.

Test Plan:
- Cold miss:
  - Stimulus: reset, read addr 0x000010; memory returns 0xA0+k for word k with 2-cycle latency, waitrequest 0.
  - Required: m_addr sequence 0x10,0x11,0x12,0x13; waitrequest high from the lookup cycle to the last refill word; RESP readdata=0xA0, valid for 1 cycle.
- Hit stream:
  - Stimulus: after the fill, reads 0x10,0x11,0x12,0x13 on consecutive cycles.
  - Required: readdata_valid on 4 consecutive cycles with 0xA0..0xA3; waitrequest stays 0; m_read never asserts.
- Conflict miss:
  - Stimulus: read 0x000110 (same idx, different tag).
  - Required: refill from 0x110; a subsequent read of 0x10 misses again.
- Flush:
  - Stimulus: flush_i for 1 cycle, then read 0x10.
  - Required: miss and refill. Flush mid-refill: data still returned, and the next read of the same address misses.
- Backpressure/reset:
  - Stimulus: m_waitrequest=1 for 5 cycles during REFILL word 1.
  - Required: m_addr/m_read stable for those cycles. Stimulus: rst asserted mid-refill. Required: all outputs reach reset values next cycle; a late m_readdata_valid produces no o_p_readdata_valid.
- Write discard:
  - Stimulus: i_p_write=1, addr 0x10, data 0xDEAD.
  - Required: no readdata_valid; a following read of 0x10 returns the cached 0xA0 with 1-cycle latency.
